// File: rtl/ube_pkg.sv
// UBE exerciser shared definitions: CSR bit positions and sequencer states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ube_pkg;

  localparam int CSR_ERR  = 15;
  localparam int CSR_BUSY = 14;
  localparam int CSR_FTM  = 11;
  localparam int CSR_NPRO = 9;
  localparam int CSR_BYTE = 8;
  localparam int CSR_DONE = 7;
  localparam int CSR_IE   = 6;
  localparam int CSR_NPRS = 5;
  localparam int CSR_GO   = 0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    DONEST,
    INTR
  } state_t;

endpackage

// File: rtl/ube_xfer_csr_if.sv
// UBE register-decode / bus-master / interrupt signal bundle around the CSR block.
// Latency: n/a (wiring only).
// Backpressure: NPR uses nprREQ held until nprACK; interrupt uses intREQ held until intACK.
// Ports: dev* write path from register decode, reg* readback, npr* DMA handshake,
//        int* interrupt handshake. slave = CSR block side, master = decode/bus side.
interface ube_xfer_csr_if #(
  parameter int WCWIDTH = 16,
  parameter int NLEVELS = 4
);
  logic               devHIBYTE;
  logic               devLOBYTE;
  logic [35:0]        devDATAI;
  logic               csrWRITE;
  logic               wcWRITE;
  logic [15:0]        regCSR;
  logic [WCWIDTH-1:0] regWC;
  logic               nprREQ;
  logic               nprACK;
  logic               nprDONE;
  logic               nprNXM;
  logic               nprBYTE;
  logic [NLEVELS-1:0] intREQ;
  logic               intACK;

  modport slave (
    input  devHIBYTE, devLOBYTE, devDATAI, csrWRITE, wcWRITE,
    input  nprACK, nprDONE, nprNXM, intACK,
    output regCSR, regWC, nprREQ, nprBYTE, intREQ
  );

  modport master (
    output devHIBYTE, devLOBYTE, devDATAI, csrWRITE, wcWRITE,
    output nprACK, nprDONE, nprNXM, intACK,
    input  regCSR, regWC, nprREQ, nprBYTE, intREQ
  );
endinterface

// File: rtl/ube_intsel.sv
// Priority encoder: BR select mask to one-hot request at the highest selected level.
// Latency: combinational.
// Backpressure: none.
// Ports: i_mask (bit0 = BR4), o_int (one-hot, bit0 = BR4, all-zero when mask empty).
module ube_intsel #(
  parameter int NLEVELS = 4
) (
  input  logic [NLEVELS-1:0] i_mask,
  output logic [NLEVELS-1:0] o_int
);

  // Scan upward so the highest set bit is the last one to claim the output.
  always_comb begin
    o_int = '0;
    for (int i = 0; i < NLEVELS; i++) begin
      if (i_mask[i]) begin
        o_int    = '0;
        o_int[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ube_xfer_csr.sv
// UBE control/status + word-count registers with the NPR transfer sequencer and interrupt.
// Latency: GO write to nprREQ 1 cycle; last nprDONE to CSR DONE 2 cycles.
// Backpressure: holds nprREQ until nprACK, intREQ until intACK; XFER aborts after TIMEOUT cycles.
// Ports: clk, rst (sync, active-high), clr (Unibus INIT, same as rst), bus (slave modport).
module ube_xfer_csr
  import ube_pkg::*;
#(
  parameter int WCWIDTH = 16,
  parameter int TIMEOUT = 255,
  parameter int NLEVELS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  ube_xfer_csr_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_err, r_done, r_ftm, r_npro, r_byte, r_ie, r_npr_req;
  logic [NLEVELS-1:0] r_br;
  logic [WCWIDTH-1:0] r_wc;
  logic [TW-1:0]      r_tmo;

  logic               w_reset, w_busy, w_go, w_npro_eff, w_tmo_hit;
  logic               w_set_err, w_wc_dec;
  logic [WCWIDTH-1:0] w_wc_eff;
  logic [NLEVELS-1:0] w_int_sel;
  logic [15:0]        w_csr;
  logic               unused_ok;

  assign w_reset   = rst | clr;
  assign w_busy    = (r_state != IDLE);
  assign w_go      = bus.csrWRITE & bus.devLOBYTE & bus.devDATAI[CSR_GO] & ~w_busy;
  // A launch sees mode/count values written in the same cycle.
  assign w_npro_eff = (bus.csrWRITE & bus.devHIBYTE) ? bus.devDATAI[CSR_NPRO] : r_npro;
  assign w_wc_eff   = bus.wcWRITE ? bus.devDATAI[WCWIDTH-1:0] : r_wc;
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
  assign unused_ok  = &{1'b0, bus.devDATAI};

  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    w_wc_dec    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nxt = (!w_npro_eff || w_wc_eff == '0) ? DONEST : REQ;
        end
      end
      REQ: begin
        if (bus.nprACK) w_state_nxt = XFER;
      end
      XFER: begin
        // NXM beats DONE; DONE beats the timeout.
        if (bus.nprNXM) begin
          w_set_err   = 1'b1;
          w_state_nxt = DONEST;
        end else if (bus.nprDONE) begin
          w_wc_dec    = (r_wc != '0);
          w_state_nxt = (r_wc <= WCWIDTH'(1)) ? DONEST : REQ;
        end else if (w_tmo_hit) begin
          w_set_err   = 1'b1;
          w_state_nxt = DONEST;
        end
      end
      DONEST: begin
        w_state_nxt = (r_ie && r_br != '0) ? INTR : IDLE;
      end
      INTR: begin
        // Leave if the request was granted or software withdrew it (IE or level cleared).
        if (bus.intACK || !r_ie || r_br == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_state   <= IDLE;
      r_npr_req <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_ftm     <= 1'b0;
      r_npro    <= 1'b0;
      r_byte    <= 1'b0;
      r_ie      <= 1'b0;
      r_br      <= '0;
      r_wc      <= '0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_npr_req <= (w_state_nxt == REQ);

      if (r_state == REQ)       r_tmo <= '0;
      else if (r_state == XFER) r_tmo <= r_tmo + TW'(1);

      // IE and BR select stay writable while busy so software can withdraw an interrupt.
      if (bus.csrWRITE && bus.devLOBYTE) begin
        r_ie <= bus.devDATAI[CSR_IE];
        r_br <= bus.devDATAI[NLEVELS:1];
      end
      if (bus.csrWRITE && bus.devHIBYTE && !w_busy) begin
        r_ftm  <= bus.devDATAI[CSR_FTM];
        r_npro <= bus.devDATAI[CSR_NPRO];
        r_byte <= bus.devDATAI[CSR_BYTE];
      end

      if (bus.wcWRITE && !w_busy) r_wc <= bus.devDATAI[WCWIDTH-1:0];
      else if (w_wc_dec)          r_wc <= r_wc - WCWIDTH'(1);

      if (w_go) begin
        r_err  <= 1'b0;
        r_done <= 1'b0;
      end
      if (w_set_err)          r_err  <= 1'b1;
      if (r_state == DONEST)  r_done <= 1'b1;
    end
  end

  always_comb begin
    w_csr           = '0;
    w_csr[CSR_ERR]  = r_err;
    w_csr[CSR_BUSY] = w_busy;
    w_csr[CSR_FTM]  = r_ftm;
    w_csr[CSR_NPRO] = r_npro;
    w_csr[CSR_BYTE] = r_byte;
    w_csr[CSR_DONE] = r_done;
    w_csr[CSR_IE]   = r_ie;
    w_csr[CSR_NPRS] = (r_state == REQ) || (r_state == XFER);
    w_csr[NLEVELS:1] = r_br;
  end

  ube_intsel #(.NLEVELS(NLEVELS)) u_intsel (
    .i_mask (r_br),
    .o_int  (w_int_sel)
  );

  assign bus.regCSR  = w_csr;
  assign bus.regWC   = r_wc;
  assign bus.nprREQ  = r_npr_req;
  assign bus.nprBYTE = r_byte;
  assign bus.intREQ  = (r_state == INTR && r_ie) ? w_int_sel : '0;

endmodule

// File: tb/tb_ube_xfer_csr.sv
// Self-checking bench for ube_xfer_csr: register access, NPR sequencing, errors, interrupts, clr.
// Latency: n/a.
// Backpressure: bench plays bus master and interrupt arbiter.
module tb_ube_xfer_csr;
  localparam int WCW = 16;
  localparam int TMO = 16;
  localparam int NLV = 4;

  logic clk = 1'b0;
  logic rst, clr;
  always #5 clk = ~clk;

  ube_xfer_csr_if #(.WCWIDTH(WCW), .NLEVELS(NLV)) bus ();

  ube_xfer_csr #(.WCWIDTH(WCW), .TIMEOUT(TMO), .NLEVELS(NLV)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always @(negedge clk) begin
    if (bus.nprREQ === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = bus.nprREQ;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [15:0] d, input logic hi, input logic lo);
    bus.devDATAI  = {20'd0, d};
    bus.devHIBYTE = hi;
    bus.devLOBYTE = lo;
    bus.csrWRITE  = 1'b1;
    tick;
    bus.csrWRITE  = 1'b0;
    bus.devHIBYTE = 1'b0;
    bus.devLOBYTE = 1'b0;
  endtask

  task automatic wc_wr(input logic [15:0] d);
    bus.devDATAI = {20'd0, d};
    bus.wcWRITE  = 1'b1;
    tick;
    bus.wcWRITE  = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.nprREQ === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic ack_now;
    bus.nprACK = 1'b1;
    tick;
    bus.nprACK = 1'b0;
  endtask

  // Bus master: wait for request, ACK after 2 cycles, DONE 2 cycles later.
  task automatic do_xfer(output bit ok);
    wait_req(ok);
    if (ok) begin
      tick; tick;
      ack_now;
      tick; tick;
      bus.nprDONE = 1'b1;
      tick;
      bus.nprDONE = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0;
    bus.devHIBYTE = 0; bus.devLOBYTE = 0; bus.devDATAI = '0;
    bus.csrWRITE = 0; bus.wcWRITE = 0;
    bus.nprACK = 0; bus.nprDONE = 0; bus.nprNXM = 0; bus.intACK = 0;
    tick; tick;
    rst = 1'b0;
    wc_wr(16'h1234);
    csr_wr(16'h0B40, 1'b1, 1'b1);
    n_checks++;
    if (bus.regCSR !== 16'h0B40) begin n_fail++; $display("FAIL rw_csr: got %h want 0b40", bus.regCSR); end
    n_checks++;
    if (bus.regWC !== 16'h1234) begin n_fail++; $display("FAIL rw_wc: got %h want 1234", bus.regWC); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (bus.regCSR !== 16'h0) begin n_fail++; $display("FAIL reset_csr: got %h want 0000", bus.regCSR); end
    n_checks++;
    if (bus.regWC !== 16'h0) begin n_fail++; $display("FAIL reset_wc: got %h want 0000", bus.regWC); end
    n_checks++;
    if (bus.nprREQ !== 1'b0 || bus.intREQ !== 4'b0 || bus.nprBYTE !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: got req=%b int=%b byte=%b want 0", bus.nprREQ, bus.intREQ, bus.nprBYTE);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int base;
    wc_wr(16'd3);
    base = req_rises;
    exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    csr_wr(16'h0201, 1'b1, 1'b1);
    n_checks++;
    if (bus.nprREQ !== 1'b1) begin n_fail++; $display("FAIL go_latency: got nprREQ=%b want 1", bus.nprREQ); end
    for (int k = 0; k < 3; k++) begin
      do_xfer(ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_req%0d: got no request want request", k); end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.regWC !== exp_v) begin n_fail++; $display("FAIL basic_wc%0d: got %0d want %0d", k, bus.regWC, exp_v); end
    end
    n_checks++;
    if (bus.regCSR[7] !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got DONE=%b want 0", bus.regCSR[7]); end
    tick;
    n_checks++;
    if (bus.regCSR !== 16'h0280) begin n_fail++; $display("FAIL basic_csr: got %h want 0280", bus.regCSR); end
    n_checks++;
    if (bus.intREQ !== 4'b0) begin n_fail++; $display("FAIL basic_int: got %b want 0000", bus.intREQ); end
    n_checks++;
    if (req_rises - base !== 3) begin n_fail++; $display("FAIL basic_pulses: got %0d want 3", req_rises - base); end
  endtask

  task automatic test_intr;
    bit ok;
    wc_wr(16'd1);
    exp_q.push_back(16'b1000);
    csr_wr(16'h0251, 1'b1, 1'b1);
    do_xfer(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL intr_req: got no request want request"); end
    tick;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.intREQ !== exp_v[3:0]) begin n_fail++; $display("FAIL intr_level: got %b want %b", bus.intREQ, exp_v[3:0]); end
    tick; tick; tick;
    n_checks++;
    if (bus.intREQ !== 4'b1000 || bus.regCSR[14] !== 1'b1) begin
      n_fail++; $display("FAIL intr_hold: got int=%b busy=%b want 1000/1", bus.intREQ, bus.regCSR[14]);
    end
    bus.intACK = 1'b1;
    tick;
    bus.intACK = 1'b0;
    n_checks++;
    if (bus.regCSR !== 16'h02D0 || bus.intREQ !== 4'b0) begin
      n_fail++; $display("FAIL intr_ack: got csr=%h int=%b want 02d0/0000", bus.regCSR, bus.intREQ);
    end
    // WC is 0: straight to DONEST then INTR on BR4 only; then software clears IE.
    exp_q.push_back(16'b0001);
    csr_wr(16'h0243, 1'b1, 1'b1);
    tick;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.intREQ !== exp_v[3:0]) begin n_fail++; $display("FAIL intr_br4: got %b want %b", bus.intREQ, exp_v[3:0]); end
    csr_wr(16'h0002, 1'b0, 1'b1);
    n_checks++;
    if (bus.intREQ !== 4'b0) begin n_fail++; $display("FAIL intr_ie_drop: got %b want 0000", bus.intREQ); end
    tick;
    n_checks++;
    if (bus.regCSR[14] !== 1'b0) begin n_fail++; $display("FAIL intr_ie_idle: got busy=%b want 0", bus.regCSR[14]); end
  endtask

  task automatic test_timeout;
    bit ok;
    wc_wr(16'd2);
    csr_wr(16'h0201, 1'b1, 1'b1);
    wait_req(ok);
    ack_now;
    repeat (TMO - 1) tick;
    n_checks++;
    if (bus.regCSR[15:14] !== 2'b01) begin n_fail++; $display("FAIL tmo_early: got err/busy=%b want 01", bus.regCSR[15:14]); end
    tick;
    n_checks++;
    if (bus.regCSR[15] !== 1'b1 || bus.regCSR[7] !== 1'b0) begin
      n_fail++; $display("FAIL tmo_err: got err=%b done=%b want 1/0", bus.regCSR[15], bus.regCSR[7]);
    end
    tick;
    n_checks++;
    if (bus.regCSR !== 16'h8280 || bus.regWC !== 16'd2) begin
      n_fail++; $display("FAIL tmo_final: got csr=%h wc=%0d want 8280/2", bus.regCSR, bus.regWC);
    end
    // NXM in the first XFER cycle.
    csr_wr(16'h0201, 1'b1, 1'b1);
    n_checks++;
    if (bus.regCSR !== 16'h4220) begin n_fail++; $display("FAIL go_clears: got %h want 4220", bus.regCSR); end
    wait_req(ok);
    ack_now;
    bus.nprNXM = 1'b1;
    tick;
    bus.nprNXM = 1'b0;
    tick;
    n_checks++;
    if (bus.regCSR !== 16'h8280 || bus.regWC !== 16'd2) begin
      n_fail++; $display("FAIL nxm_final: got csr=%h wc=%0d want 8280/2", bus.regCSR, bus.regWC);
    end
    // DONE in the timeout cycle wins, then DONE+NXM together: NXM wins.
    csr_wr(16'h0201, 1'b1, 1'b1);
    wait_req(ok);
    ack_now;
    repeat (TMO - 1) tick;
    bus.nprDONE = 1'b1;
    tick;
    bus.nprDONE = 1'b0;
    n_checks++;
    if (bus.regCSR[15] !== 1'b0 || bus.nprREQ !== 1'b1 || bus.regWC !== 16'd1) begin
      n_fail++; $display("FAIL tmo_done_wins: got err=%b req=%b wc=%0d want 0/1/1", bus.regCSR[15], bus.nprREQ, bus.regWC);
    end
    ack_now;
    bus.nprDONE = 1'b1; bus.nprNXM = 1'b1;
    tick;
    bus.nprDONE = 1'b0; bus.nprNXM = 1'b0;
    tick;
    n_checks++;
    if (bus.regCSR !== 16'h8280 || bus.regWC !== 16'd1) begin
      n_fail++; $display("FAIL nxm_wins: got csr=%h wc=%0d want 8280/1", bus.regCSR, bus.regWC);
    end
  endtask

  task automatic test_busy;
    bit ok;
    int base;
    wc_wr(16'd3);
    base = req_rises;
    csr_wr(16'h0201, 1'b1, 1'b1);
    wait_req(ok);
    ack_now;
    exp_q.push_back(16'h427E);
    csr_wr(16'hFFFF, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.regCSR !== exp_v) begin n_fail++; $display("FAIL busy_csr: got %h want %h", bus.regCSR, exp_v); end
    n_checks++;
    if (bus.nprBYTE !== 1'b0) begin n_fail++; $display("FAIL busy_byte: got %b want 0", bus.nprBYTE); end
    wc_wr(16'd5);
    n_checks++;
    if (bus.regWC !== 16'd3) begin n_fail++; $display("FAIL busy_wc: got %0d want 3", bus.regWC); end
    bus.nprDONE = 1'b1;
    tick;
    bus.nprDONE = 1'b0;
    do_xfer(ok);
    do_xfer(ok);
    tick;
    n_checks++;
    if (bus.intREQ !== 4'b1000) begin n_fail++; $display("FAIL busy_int: got %b want 1000", bus.intREQ); end
    bus.intACK = 1'b1;
    tick;
    bus.intACK = 1'b0;
    n_checks++;
    if (bus.regWC !== 16'd0 || req_rises - base !== 3 || bus.regCSR[14] !== 1'b0) begin
      n_fail++; $display("FAIL busy_end: got wc=%0d pulses=%0d busy=%b want 0/3/0", bus.regWC, req_rises - base, bus.regCSR[14]);
    end
  endtask

  task automatic test_noop;
    int base;
    base = req_rises;
    csr_wr(16'h0201, 1'b1, 1'b1);
    n_checks++;
    if (bus.regCSR !== 16'h4200 || bus.nprREQ !== 1'b0) begin
      n_fail++; $display("FAIL wc0_donest: got csr=%h req=%b want 4200/0", bus.regCSR, bus.nprREQ);
    end
    tick;
    n_checks++;
    if (bus.regCSR !== 16'h0280) begin n_fail++; $display("FAIL wc0_done: got %h want 0280", bus.regCSR); end
    wc_wr(16'd4);
    csr_wr(16'h0001, 1'b1, 1'b1);
    tick;
    n_checks++;
    if (bus.regCSR !== 16'h0080 || bus.regWC !== 16'd4) begin
      n_fail++; $display("FAIL npro0_done: got csr=%h wc=%0d want 0080/4", bus.regCSR, bus.regWC);
    end
    n_checks++;
    if (req_rises - base !== 0) begin n_fail++; $display("FAIL noop_pulses: got %0d want 0", req_rises - base); end
    csr_wr(16'h0100, 1'b1, 1'b1);
    n_checks++;
    if (bus.nprBYTE !== 1'b1) begin n_fail++; $display("FAIL byte_mode: got %b want 1", bus.nprBYTE); end
  endtask

  task automatic test_clr;
    wc_wr(16'd2);
    csr_wr(16'h0201, 1'b1, 1'b1);
    n_checks++;
    if (bus.nprREQ !== 1'b1) begin n_fail++; $display("FAIL clr_pre_req: got %b want 1", bus.nprREQ); end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n_checks++;
    if (bus.regCSR !== 16'h0 || bus.regWC !== 16'd0 || bus.nprREQ !== 1'b0 || bus.intREQ !== 4'b0) begin
      n_fail++; $display("FAIL clr_req: got csr=%h wc=%0d req=%b int=%b want 0", bus.regCSR, bus.regWC, bus.nprREQ, bus.intREQ);
    end
    wc_wr(16'd3);
    csr_wr(16'h0043, 1'b1, 1'b1);
    tick;
    n_checks++;
    if (bus.intREQ !== 4'b0001) begin n_fail++; $display("FAIL clr_pre_int: got %b want 0001", bus.intREQ); end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n_checks++;
    if (bus.regCSR !== 16'h0 || bus.regWC !== 16'd0 || bus.nprREQ !== 1'b0 || bus.intREQ !== 4'b0) begin
      n_fail++; $display("FAIL clr_intr: got csr=%h wc=%0d req=%b int=%b want 0", bus.regCSR, bus.regWC, bus.nprREQ, bus.intREQ);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_intr;
    test_timeout;
    test_busy;
    test_noop;
    test_clr;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
